// File: rtl/instr_encoder_pkg.sv
// Shared RV32I encoding constants: opcodes, funct3/funct7, operation classes and ALU funct codes.
// Purely declarative; no latency or backpressure of its own.
package instr_encoder_pkg;

  localparam int ALU_FUNCT_WIDTH = 4;

  typedef enum logic [1:0] {
    CLS_ALU_REG = 2'd0,
    CLS_ALU_IMM = 2'd1,
    CLS_LOAD    = 2'd2,
    CLS_STORE   = 2'd3
  } in_class_e;

  // ALU funct codes as driven by the core's decoder; 10..15 are undefined.
  localparam logic [ALU_FUNCT_WIDTH-1:0] FN_ADD  = 4'd0;
  localparam logic [ALU_FUNCT_WIDTH-1:0] FN_SUB  = 4'd1;
  localparam logic [ALU_FUNCT_WIDTH-1:0] FN_SLL  = 4'd2;
  localparam logic [ALU_FUNCT_WIDTH-1:0] FN_SLT  = 4'd3;
  localparam logic [ALU_FUNCT_WIDTH-1:0] FN_SLTU = 4'd4;
  localparam logic [ALU_FUNCT_WIDTH-1:0] FN_XOR  = 4'd5;
  localparam logic [ALU_FUNCT_WIDTH-1:0] FN_SRL  = 4'd6;
  localparam logic [ALU_FUNCT_WIDTH-1:0] FN_SRA  = 4'd7;
  localparam logic [ALU_FUNCT_WIDTH-1:0] FN_OR   = 4'd8;
  localparam logic [ALU_FUNCT_WIDTH-1:0] FN_AND  = 4'd9;

  localparam logic [6:0] OP_ALU_REG = 7'b0110011;
  localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_WORD    = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Which immediate format a class/funct pair uses; drives the range check.
  typedef enum logic [1:0] {
    IMM_NONE  = 2'd0,
    IMM_12    = 2'd1,
    IMM_SHIFT = 2'd2
  } imm_kind_e;

  function automatic logic is_shift_funct(input logic [ALU_FUNCT_WIDTH-1:0] fn);
    return (fn == FN_SLL) || (fn == FN_SRL) || (fn == FN_SRA);
  endfunction

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input channel and instruction-word output channel, both valid/ready.
// The encoder uses the slave modport; the producer/consumer side uses master.
interface instr_encoder_if #(
  parameter int N = 32
);
  import instr_encoder_pkg::*;

  logic                       in_valid;
  logic                       in_ready;
  in_class_e                  in_class;
  logic [ALU_FUNCT_WIDTH-1:0] in_alu_funct;
  logic [4:0]                 in_rs1;
  logic [4:0]                 in_rs2;
  logic [4:0]                 in_rd;
  logic [N-1:0]               in_immed;

  logic                       out_valid;
  logic                       out_ready;
  logic [31:0]                out_instr;
  logic [N-1:0]               out_addr;

  modport master (
    output in_valid, in_class, in_alu_funct, in_rs1, in_rs2, in_rd, in_immed, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, in_class, in_alu_funct, in_rs1, in_rs2, in_rd, in_immed, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );

endinterface

// File: rtl/instr_encoder_field_pack.sv
// Combinational field packer: class/funct/regs/immediate -> RV32I word plus illegal and range flags.
// Zero latency, no state; INSTR_ENCODER_RANGE_CHECK_EN enables the immediate range flag.
module instr_field_pack
  import instr_encoder_pkg::*;
#(
  parameter int N = 32
) (
  input  in_class_e                  cls,
  input  logic [ALU_FUNCT_WIDTH-1:0] funct,
  input  logic [4:0]                 rs1,
  input  logic [4:0]                 rs2,
  input  logic [4:0]                 rd,
  input  logic [N-1:0]               immed,
  output logic [31:0]                instr,
  output logic                       illegal,
  output logic                       range_bad
);

  logic [2:0] f3;
  logic [6:0] f7;
  logic       funct_ok;
  logic       shift_op;
  imm_kind_e  imm_kind;

  always_comb begin
    f3       = F3_ADD_SUB;
    f7       = F7_BASE;
    funct_ok = 1'b1;
    case (funct)
      FN_ADD:  f3 = F3_ADD_SUB;
      FN_SUB:  f7 = F7_ALT;
      FN_SLL:  f3 = F3_SLL;
      FN_SLT:  f3 = F3_SLT;
      FN_SLTU: f3 = F3_SLTU;
      FN_XOR:  f3 = F3_XOR;
      FN_SRL:  f3 = F3_SRL_SRA;
      FN_SRA:  begin f3 = F3_SRL_SRA; f7 = F7_ALT; end
      FN_OR:   f3 = F3_OR;
      FN_AND:  f3 = F3_AND;
      default: funct_ok = 1'b0;
    endcase
  end

  assign shift_op = is_shift_funct(funct);

  // Illegal bundles collapse to a NOP so the program image keeps its layout.
  always_comb begin
    instr    = NOP_INSTR;
    illegal  = 1'b0;
    imm_kind = IMM_NONE;
    case (cls)
      CLS_ALU_REG: begin
        if (!funct_ok) illegal = 1'b1;
        else           instr   = {f7, rs2, rs1, f3, rd, OP_ALU_REG};
      end
      CLS_ALU_IMM: begin
        if (!funct_ok || funct == FN_SUB) begin
          illegal = 1'b1;
        end else if (shift_op) begin
          instr    = {f7, immed[4:0], rs1, f3, rd, OP_ALU_IMM};
          imm_kind = IMM_SHIFT;
        end else begin
          instr    = {immed[11:0], rs1, f3, rd, OP_ALU_IMM};
          imm_kind = IMM_12;
        end
      end
      CLS_LOAD: begin
        instr    = {immed[11:0], rs1, F3_WORD, rd, OP_LOAD};
        imm_kind = IMM_12;
      end
      CLS_STORE: begin
        instr    = {immed[11:5], rs2, rs1, F3_WORD, immed[4:0], OP_STORE};
        imm_kind = IMM_12;
      end
      default: illegal = 1'b1;
    endcase
  end

`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  localparam logic signed [N-1:0] IMM12_MIN = N'(-2048);
  localparam logic signed [N-1:0] IMM12_MAX = N'(2047);
  localparam logic signed [N-1:0] SHAMT_MAX = N'(31);

  always_comb begin
    range_bad = 1'b0;
    case (imm_kind)
      IMM_12:    range_bad = ($signed(immed) < IMM12_MIN) || ($signed(immed) > IMM12_MAX);
      IMM_SHIFT: range_bad = ($signed(immed) < 0) || ($signed(immed) > SHAMT_MAX);
      default:   range_bad = 1'b0;
    endcase
  end
`else
  logic unused_imm;
  assign unused_imm = ^{immed[N-1:12], imm_kind};
  assign range_bad  = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: field bundle in, packed word plus word-aligned imem address out.
// 1-cycle latency, full throughput; in_ready = !out_valid || out_ready. Macro: INSTR_ENCODER_RANGE_CHECK_EN.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int N     = 32,
  parameter int DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  instr_encoder_if.slave    bus,
  output logic              illegal_err,
  output logic              range_err,
  input  logic              clear_err,
  input  logic              addr_rst
);

  localparam logic [N-1:0] ADDR_LAST = N'(4 * (DEPTH - 1));
  localparam logic [N-1:0] ADDR_STEP = N'(4);

  logic [31:0]  pack_instr;
  logic         pack_illegal;
  logic         pack_range;
  logic         take;
  logic         give;
  logic         out_valid_q;
  logic [31:0]  out_instr_q;
  logic [N-1:0] addr_q;

  assign bus.in_ready  = !out_valid_q || bus.out_ready;
  assign take          = bus.in_valid && bus.in_ready;
  assign give          = out_valid_q && bus.out_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_instr = out_instr_q;
  assign bus.out_addr  = addr_q;

  instr_field_pack #(.N(N)) u_pack (
    .cls       (bus.in_class),
    .funct     (bus.in_alu_funct),
    .rs1       (bus.in_rs1),
    .rs2       (bus.in_rs2),
    .rd        (bus.in_rd),
    .immed     (bus.in_immed),
    .instr     (pack_instr),
    .illegal   (pack_illegal),
    .range_bad (pack_range)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_instr_q <= NOP_INSTR;
    end else if (take) begin
      out_valid_q <= 1'b1;
      out_instr_q <= pack_instr;
    end else if (give) begin
      out_valid_q <= 1'b0;
    end
  end

  // addr_q is the address of the word currently held; it moves only when that word leaves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else if (addr_rst) begin
      addr_q <= '0;
    end else if (give) begin
      addr_q <= (addr_q == ADDR_LAST) ? '0 : addr_q + ADDR_STEP;
    end
  end

  // A fresh error outranks a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_err <= 1'b0;
      range_err   <= 1'b0;
    end else begin
      illegal_err <= (take && pack_illegal) || (illegal_err && !clear_err);
      range_err   <= (take && pack_range)   || (range_err   && !clear_err);
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder (DEPTH=4 so address wrap is exercised quickly).
module tb_instr_encoder;
  import instr_encoder_pkg::*;

  localparam int TB_DEPTH = 4;
  localparam logic [31:0] ADDR_LAST = 32'(4 * (TB_DEPTH - 1));
`ifdef INSTR_ENCODER_RANGE_CHECK_EN
  localparam logic [31:0] RC = 32'd1;
`else
  localparam logic [31:0] RC = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic clear_err = 1'b0;
  logic addr_rst = 1'b0;
  logic illegal_err;
  logic range_err;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr = '0;

  instr_encoder_if #(.N(32)) bus ();

  instr_encoder #(.N(32), .DEPTH(TB_DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .illegal_err (illegal_err),
    .range_err   (range_err),
    .clear_err   (clear_err),
    .addr_rst    (addr_rst)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Output monitor: every held word is compared to the scoreboard head, popped on transfer.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_addr = '0;
    end else begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_word", 32'(bus.out_valid), 32'd0);
        end else begin
          chk("instr", bus.out_instr, exp_q[0]);
          chk("addr", bus.out_addr, exp_addr);
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      if (addr_rst) exp_addr = '0;
      else if (bus.out_valid && bus.out_ready)
        exp_addr = (exp_addr == ADDR_LAST) ? '0 : exp_addr + 32'd4;
    end
  end

  task automatic send(input in_class_e cls, input logic [3:0] fn, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm,
                      input logic [31:0] exp);
    int n = 0;
    logic ok = 1'b0;
    bus.in_valid     = 1'b1;
    bus.in_class     = cls;
    bus.in_alu_funct = fn;
    bus.in_rs1       = rs1;
    bus.in_rs2       = rs2;
    bus.in_rd        = rd;
    bus.in_immed     = imm;
    exp_q.push_back(exp);
    do begin
      @(negedge clk);
      ok = bus.in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 200);
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    bus.in_valid = 1'b0;
    while ((exp_q.size() != 0 || bus.out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic pulse_clear();
    clear_err = 1'b1;
    @(posedge clk);
    #1;
    clear_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n            = 1'b1;
    bus.in_valid     = 1'b0;
    bus.in_class     = CLS_ALU_REG;
    bus.in_alu_funct = FN_ADD;
    bus.in_rs1       = '0;
    bus.in_rs2       = '0;
    bus.in_rd        = '0;
    bus.in_immed     = '0;
    bus.out_ready    = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_instr", bus.out_instr, 32'h0000_0013);
    chk("rst_out_addr", bus.out_addr, 32'd0);
    chk("rst_illegal", 32'(illegal_err), 32'd0);
    chk("rst_range", 32'(range_err), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;

    // Back-to-back encodings; 11 words walk the 4-entry address space nearly three times.
    send(CLS_ALU_REG, FN_ADD,  5'd1,  5'd2,  5'd3,  32'd0,   32'h002081B3);
    send(CLS_ALU_REG, FN_SUB,  5'd6,  5'd7,  5'd5,  32'd0,   32'h407302B3);
    send(CLS_ALU_IMM, FN_ADD,  5'd0,  5'd0,  5'd1,  -32'sd1, 32'hFFF00093);
    send(CLS_ALU_IMM, FN_SRA,  5'd4,  5'd0,  5'd4,  32'd3,   32'h40325213);
    send(CLS_STORE,   4'd15,   5'd1,  5'd2,  5'd31, 32'd8,   32'h0020A423);
    send(CLS_LOAD,    4'd15,   5'd1,  5'd31, 5'd3,  32'd4,   32'h0040A183);
    send(CLS_ALU_REG, FN_SLL,  5'd2,  5'd3,  5'd1,  32'd0,   32'h003110B3);
    send(CLS_ALU_REG, FN_AND,  5'd11, 5'd12, 5'd10, 32'd0,   32'h00C5F533);
    send(CLS_ALU_IMM, FN_XOR,  5'd6,  5'd0,  5'd5,  32'd2047, 32'h7FF34293);
    send(CLS_ALU_IMM, FN_SLL,  5'd1,  5'd0,  5'd1,  32'd31,  32'h01F09093);
    send(CLS_LOAD,    FN_ADD,  5'd1,  5'd0,  5'd3,  -32'sd2048, 32'h8000A183);
    drain();
    @(negedge clk);
    chk("legal_no_illegal", 32'(illegal_err), 32'd0);
    chk("boundary_no_range", 32'(range_err), 32'd0);
    @(posedge clk);
    #1;

    // Backpressure: consumer stalls three cycles while the producer keeps in_valid high.
    bus.out_ready = 1'b0;
    fork
      begin
        send(CLS_ALU_REG, FN_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 32'h002081B3);
        send(CLS_ALU_REG, FN_SUB, 5'd6, 5'd7, 5'd5, 32'd0, 32'h407302B3);
        send(CLS_ALU_REG, FN_SLL, 5'd2, 5'd3, 5'd1, 32'd0, 32'h003110B3);
        send(CLS_ALU_REG, FN_AND, 5'd11, 5'd12, 5'd10, 32'd0, 32'h00C5F533);
        bus.in_valid = 1'b0;
      end
      begin
        @(posedge clk);
        repeat (3) begin
          @(negedge clk);
          chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
          @(posedge clk);
        end
        #1 bus.out_ready = 1'b1;
      end
    join
    drain();

    // Address reset while idle, then coinciding with an output transfer.
    addr_rst = 1'b1;
    @(posedge clk);
    #1 addr_rst = 1'b0;
    send(CLS_ALU_REG, FN_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 32'h002081B3);
    fork
      begin
        send(CLS_ALU_REG, FN_SUB, 5'd6, 5'd7, 5'd5, 32'd0, 32'h407302B3);
        send(CLS_ALU_REG, FN_AND, 5'd11, 5'd12, 5'd10, 32'd0, 32'h00C5F533);
        send(CLS_ALU_REG, FN_SLL, 5'd2, 5'd3, 5'd1, 32'd0, 32'h003110B3);
        bus.in_valid = 1'b0;
      end
      begin
        @(posedge clk);
        #1 addr_rst = 1'b1;
        @(posedge clk);
        #1 addr_rst = 1'b0;
      end
    join
    drain();

    // Illegal bundles and sticky-flag clearing.
    send(CLS_ALU_IMM, FN_SUB, 5'd1, 5'd0, 5'd1, 32'd5, 32'h0000_0013);
    drain();
    @(negedge clk);
    chk("illegal_subi", 32'(illegal_err), 32'd1);
    @(posedge clk);
    #1 pulse_clear();
    @(negedge clk);
    chk("illegal_cleared", 32'(illegal_err), 32'd0);
    @(posedge clk);
    #1;
    send(CLS_ALU_REG, 4'd12, 5'd1, 5'd2, 5'd3, 32'd0, 32'h0000_0013);
    drain();
    @(negedge clk);
    chk("illegal_funct", 32'(illegal_err), 32'd1);
    @(posedge clk);
    #1 clear_err = 1'b1;
    send(CLS_ALU_IMM, FN_SUB, 5'd2, 5'd0, 5'd2, 32'd1, 32'h0000_0013);
    clear_err = 1'b0;
    drain();
    @(negedge clk);
    chk("illegal_beats_clear", 32'(illegal_err), 32'd1);
    @(posedge clk);
    #1 pulse_clear();

    // Out-of-range immediates: always truncated, flagged only with the range check built in.
    send(CLS_ALU_IMM, FN_ADD, 5'd0, 5'd0, 5'd1, 32'd2048, 32'h80000093);
    drain();
    @(negedge clk);
    chk("range_addi", 32'(range_err), RC);
    chk("range_not_illegal", 32'(illegal_err), 32'd0);
    @(posedge clk);
    #1 pulse_clear();
    @(negedge clk);
    chk("range_cleared", 32'(range_err), 32'd0);
    @(posedge clk);
    #1;
    send(CLS_ALU_IMM, FN_SLL, 5'd1, 5'd0, 5'd1, 32'd32, 32'h00009093);
    drain();
    @(negedge clk);
    chk("range_slli", 32'(range_err), RC);
    @(posedge clk);
    #1;

    // Reset while a word is held: it must vanish and state return to reset values.
    bus.out_ready = 1'b0;
    send(CLS_ALU_REG, FN_ADD, 5'd1, 5'd2, 5'd3, 32'd0, 32'h002081B3);
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_out_instr", bus.out_instr, 32'h0000_0013);
    chk("midrst_out_addr", bus.out_addr, 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrst_range", 32'(range_err), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.out_ready = 1'b1;
    send(CLS_ALU_IMM, FN_SRA, 5'd4, 5'd0, 5'd4, 32'd3, 32'h40325213);
    drain();

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
